// File: rtl/channel_denoise_filter.sv
// channel_denoise_filter
//   Per-lane moving-average denoiser for the four noisy lanes leaving the AWGN channel.
//   Each lane keeps a circular window of N = 2**LOG2_N samples and a running sum. The block
//   emits the window mean (floored) once the window is full. A bypass path has the same latency.
// Ports
//   clk, reset               rising-edge clock, asynchronous active-high reset
//   filter_off               1 = registered pass-through, 0 = filtered output
//   in_valid, data_in1..4    new signed sample set on each lane
//   out_valid, data_out1..4  single-cycle result pulse and held result data
//   primed                   window has been filled; filtered results are meaningful
module channel_denoise_filter #(
    parameter int unsigned LOG2_N = 2,
    parameter int unsigned W      = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         filter_off,
    input  logic         in_valid,
    input  logic [W-1:0] data_in1,
    input  logic [W-1:0] data_in2,
    input  logic [W-1:0] data_in3,
    input  logic [W-1:0] data_in4,
    output logic         out_valid,
    output logic [W-1:0] data_out1,
    output logic [W-1:0] data_out2,
    output logic [W-1:0] data_out3,
    output logic [W-1:0] data_out4,
    output logic         primed
);

    localparam int unsigned N  = 1 << LOG2_N;
    localparam int unsigned SW = W + LOG2_N;

    typedef enum logic [0:0] {StFill, StRun} state_e;

    state_e            state_q, state_d;
    logic [LOG2_N-1:0] fill_cnt_q, fill_cnt_d;
    logic [LOG2_N-1:0] wr_ptr_q;

    logic [W-1:0]  din      [4];
    logic [W-1:0]  win_q    [4][N];
    logic [SW-1:0] sum_q    [4];
    logic [SW-1:0] sum_d    [4];
    logic [W-1:0]  dout_q   [4];
    logic [W-1:0]  dout_d   [4];
    logic          out_valid_q;
    logic          emit;
    logic          last_fill;

    assign din[0] = data_in1;
    assign din[1] = data_in2;
    assign din[2] = data_in3;
    assign din[3] = data_in4;

    // Running sum: add the incoming sample, drop the one it overwrites.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            sum_d[k] = sum_q[k]
                     + {{LOG2_N{din[k][W-1]}}, din[k]}
                     - {{LOG2_N{win_q[k][wr_ptr_q][W-1]}}, win_q[k][wr_ptr_q]};
        end
    end

    // Window storage, sums and write pointer advance on every accepted sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            for (int k = 0; k < 4; k++) begin
                sum_q[k] <= '0;
                for (int i = 0; i < N; i++) begin
                    win_q[k][i] <= '0;
                end
            end
        end else if (in_valid) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
            for (int k = 0; k < 4; k++) begin
                sum_q[k]              <= sum_d[k];
                win_q[k][wr_ptr_q]    <= din[k];
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StFill;
            fill_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        case (state_q)
            StFill: begin
                if (in_valid) begin
                    fill_cnt_d = fill_cnt_q + 1'b1;
                    if (fill_cnt_q == LOG2_N'(N - 1)) begin
                        state_d = StRun;
                    end
                end
            end
            StRun:   state_d = StRun;
            default: state_d = StFill;
        endcase
    end

    // FSM outputs and next result
    always_comb begin
        primed    = (state_q == StRun);
        last_fill = (state_q == StFill) && (fill_cnt_q == LOG2_N'(N - 1));
        emit      = in_valid && (filter_off || primed || last_fill);
        for (int k = 0; k < 4; k++) begin
            // Upper slice of the sum is the arithmetic shift by LOG2_N (floors toward -inf).
            dout_d[k] = filter_off ? din[k] : sum_d[k][SW-1:LOG2_N];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                dout_q[k] <= '0;
            end
        end else begin
            out_valid_q <= emit;
            if (emit) begin
                for (int k = 0; k < 4; k++) begin
                    dout_q[k] <= dout_d[k];
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign data_out1 = dout_q[0];
    assign data_out2 = dout_q[1];
    assign data_out3 = dout_q[2];
    assign data_out4 = dout_q[3];

endmodule

// File: tb/tb_channel_denoise_filter.sv
module tb_channel_denoise_filter;

    logic        clk = 1'b0;
    logic        reset;
    logic        filter_off;
    logic        in_valid;
    logic [15:0] data_in1, data_in2, data_in3, data_in4;
    logic        out_valid;
    logic [15:0] data_out1, data_out2, data_out3, data_out4;
    logic        primed;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] exp_q [$];

    localparam logic [15:0] L2 = 16'h0017;
    localparam logic [15:0] L3 = 16'h00d1;
    localparam logic [15:0] L4 = 16'h00c5;

    always #5 clk = ~clk;

    channel_denoise_filter #(.LOG2_N(2), .W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .filter_off (filter_off),
        .in_valid   (in_valid),
        .data_in1   (data_in1),
        .data_in2   (data_in2),
        .data_in3   (data_in3),
        .data_in4   (data_in4),
        .out_valid  (out_valid),
        .data_out1  (data_out1),
        .data_out2  (data_out2),
        .data_out3  (data_out3),
        .data_out4  (data_out4),
        .primed     (primed)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic fo, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] c, input logic [15:0] d, input logic expect_out,
                        input logic [15:0] e1, input logic [15:0] e2, input logic [15:0] e3,
                        input logic [15:0] e4);
        filter_off = fo;
        in_valid   = 1'b1;
        data_in1   = a;
        data_in2   = b;
        data_in3   = c;
        data_in4   = d;
        if (expect_out) exp_q.push_back({e1, e2, e3, e4});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        data_in1 = 'x;
        data_in2 = 'x;
        data_in3 = 'x;
        data_in4 = 'x;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every presented result must match the oldest expected entry.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (!reset && out_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_out_valid: got out_valid=1 data_out1=0x%0h, expected none",
                             data_out1);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_data_out1", {16'h0, data_out1}, {16'h0, e[63:48]});
                    check("sb_data_out2", {16'h0, data_out2}, {16'h0, e[47:32]});
                    check("sb_data_out3", {16'h0, data_out3}, {16'h0, e[31:16]});
                    check("sb_data_out4", {16'h0, data_out4}, {16'h0, e[15:0]});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset      = 1'b1;
        filter_off = 1'b0;
        in_valid   = 1'b0;
        data_in1   = 'x;
        data_in2   = 'x;
        data_in3   = 'x;
        data_in4   = 'x;
        idle(3);
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_primed", {31'h0, primed}, 32'h0);
        check("rst_data_out1", {16'h0, data_out1}, 32'h0);
        check("rst_data_out4", {16'h0, data_out4}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Constant lanes: output appears only with the 4th sample.
        for (int i = 0; i < 3; i++) send(1'b0, 16'd5, L2, L3, L4, 1'b0, 0, 0, 0, 0);
        check("fill_primed", {31'h0, primed}, 32'h0);
        send(1'b0, 16'd5, L2, L3, L4, 1'b1, 16'd5, L2, L3, L4);
        check("run_primed", {31'h0, primed}, 32'h1);

        // Lane 1 ramps down to 0, then steps to 8.
        send(1'b0, 16'd0, L2, L3, L4, 1'b1, 16'd3, L2, L3, L4);
        send(1'b0, 16'd0, L2, L3, L4, 1'b1, 16'd2, L2, L3, L4);
        send(1'b0, 16'd0, L2, L3, L4, 1'b1, 16'd1, L2, L3, L4);
        send(1'b0, 16'd0, L2, L3, L4, 1'b1, 16'd0, L2, L3, L4);
        send(1'b0, 16'd8, L2, L3, L4, 1'b1, 16'd2, L2, L3, L4);
        send(1'b0, 16'd8, L2, L3, L4, 1'b1, 16'd4, L2, L3, L4);
        send(1'b0, 16'd8, L2, L3, L4, 1'b1, 16'd6, L2, L3, L4);
        send(1'b0, 16'd8, L2, L3, L4, 1'b1, 16'd8, L2, L3, L4);

        // Signed samples: final window sum -6 floors to -2.
        send(1'b0, 16'hffff, L2, L3, L4, 1'b1, 16'd5, L2, L3, L4);
        send(1'b0, 16'hfffe, L2, L3, L4, 1'b1, 16'd3, L2, L3, L4);
        send(1'b0, 16'hffff, L2, L3, L4, 1'b1, 16'd1, L2, L3, L4);
        send(1'b0, 16'hfffe, L2, L3, L4, 1'b1, 16'hfffe, L2, L3, L4);

        // Gaps: 1,0,0,1 valid pattern; data held across the gap.
        send(1'b0, 16'hffff, L2, L3, L4, 1'b1, 16'hfffe, L2, L3, L4);
        idle(2);
        check("gap_out_valid", {31'h0, out_valid}, 32'h0);
        check("gap_hold_data_out1", {16'h0, data_out1}, 32'h0000fffe);
        // Window now -1,7,-1,-2 -> sum 3 -> 0.
        send(1'b0, 16'd7, L2, L3, L4, 1'b1, 16'd0, L2, L3, L4);

        // Bypass one sample, then filtered result continues from the updated window.
        send(1'b1, 16'h1234, L2, L3, L4, 1'b1, 16'h1234, L2, L3, L4);
        send(1'b0, 16'd0, L2, L3, L4, 1'b1, 16'h048e, L2, L3, L4);

        // Reset mid-stream: immediate drop, then refill takes 4 samples again.
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_out_valid", {31'h0, out_valid}, 32'h0);
        check("midrst_primed", {31'h0, primed}, 32'h0);
        check("midrst_data_out1", {16'h0, data_out1}, 32'h0);
        check("midrst_data_out2", {16'h0, data_out2}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) send(1'b0, 16'd9, L2, L3, L4, 1'b0, 0, 0, 0, 0);
        check("refill_primed", {31'h0, primed}, 32'h0);
        check("refill_data_out1", {16'h0, data_out1}, 32'h0);

        // Bypass from reset.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        send(1'b1, 16'h00a1, 16'd0, 16'd0, 16'd0, 1'b1, 16'h00a1, 16'd0, 16'd0, 16'd0);
        check("bypass_primed", {31'h0, primed}, 32'h0);
        check("bypass_out_valid", {31'h0, out_valid}, 32'h1);
        idle(2);
        check("bypass_pulse_ended", {31'h0, out_valid}, 32'h0);

        check("scoreboard_drained", exp_q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
